// File: rtl/nasti_bram_bridge.sv
// rtl/nasti_bram_bridge.sv - NASTI (AXI4) burst slave to single-port BRAM bridge
// Optional feature macro: NASTI_BRAM_WRAP_EN (WRAP bursts wrap at (len+1)*2^size; otherwise treated as INCR)
module nasti_bram_bridge #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 64,
   parameter int BRAM_ADDR_WIDTH = 64,
   parameter int ID_WIDTH        = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   // write address channel
   input  logic [ID_WIDTH-1:0]        s_nasti_awid,
   input  logic [ADDR_WIDTH-1:0]      s_nasti_awaddr,
   input  logic [7:0]                 s_nasti_awlen,
   input  logic [2:0]                 s_nasti_awsize,
   input  logic [1:0]                 s_nasti_awburst,
   input  logic                       s_nasti_awvalid,
   output logic                       s_nasti_awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0]      s_nasti_wdata,
   input  logic [DATA_WIDTH/8-1:0]    s_nasti_wstrb,
   input  logic                       s_nasti_wlast,
   input  logic                       s_nasti_wvalid,
   output logic                       s_nasti_wready,
   // write response channel
   output logic [ID_WIDTH-1:0]        s_nasti_bid,
   output logic [1:0]                 s_nasti_bresp,
   output logic                       s_nasti_bvalid,
   input  logic                       s_nasti_bready,
   // read address channel
   input  logic [ID_WIDTH-1:0]        s_nasti_arid,
   input  logic [ADDR_WIDTH-1:0]      s_nasti_araddr,
   input  logic [7:0]                 s_nasti_arlen,
   input  logic [2:0]                 s_nasti_arsize,
   input  logic [1:0]                 s_nasti_arburst,
   input  logic                       s_nasti_arvalid,
   output logic                       s_nasti_arready,
   // read data channel
   output logic [ID_WIDTH-1:0]        s_nasti_rid,
   output logic [DATA_WIDTH-1:0]      s_nasti_rdata,
   output logic [1:0]                 s_nasti_rresp,
   output logic                       s_nasti_rlast,
   output logic                       s_nasti_rvalid,
   input  logic                       s_nasti_rready,
   // BRAM port
   output logic                       bram_clk,
   output logic                       bram_rst,
   output logic                       bram_en,
   output logic [DATA_WIDTH/8-1:0]    bram_we,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0]      bram_wrdata,
   input  logic [DATA_WIDTH-1:0]      bram_rddata
);

   localparam int STRB = DATA_WIDTH / 8;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_RESP,
      RD_ISSUE,
      RD_DATA
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [7:0]            beat_q;
   logic                  prio_wr;
   logic                  rd_fresh;
   logic [DATA_WIDTH-1:0] rd_hold;

   logic collide, grant_wr, grant_rd, w_hs, r_hs, last_beat;

   // Round-robin only matters on a collision; the pointer flips each time one is resolved
   assign collide   = s_nasti_awvalid && s_nasti_arvalid;
   assign grant_wr  = s_nasti_awvalid && (!s_nasti_arvalid || prio_wr);
   assign grant_rd  = s_nasti_arvalid && !grant_wr;
   assign w_hs      = (state == WR_DATA) && s_nasti_wvalid;
   assign r_hs      = (state == RD_DATA) && s_nasti_rready;
   assign last_beat = (beat_q == len_q);

   assign step      = ADDR_WIDTH'(1) << size_q;
   assign incr_addr = (cur_addr + step) & ~(step - ADDR_WIDTH'(1));

`ifdef NASTI_BRAM_WRAP_EN
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] wrap_addr;
   // Wrap window is (len+1)*2^size bytes, aligned to its own size
   assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
   assign wrap_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
`endif

   // Address of the next beat according to the latched burst type
   always_comb begin
      next_addr = incr_addr;
      if (burst_q == BURST_FIXED) begin
         next_addr = cur_addr;
      end else if (burst_q == BURST_WRAP) begin
`ifdef NASTI_BRAM_WRAP_EN
         next_addr = wrap_addr;
`else
         next_addr = incr_addr;
`endif
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_wr)      state_nxt = WR_DATA;
            else if (grant_rd) state_nxt = RD_ISSUE;
         end
         WR_DATA:  if (w_hs && (s_nasti_wlast || last_beat)) state_nxt = WR_RESP;
         WR_RESP:  if (s_nasti_bready) state_nxt = IDLE;
         RD_ISSUE: state_nxt = RD_DATA;
         RD_DATA:  if (r_hs) state_nxt = last_beat ? IDLE : RD_ISSUE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output decode: handshake readies/valids and single-cycle BRAM strobes
   always_comb begin
      s_nasti_awready = 1'b0;
      s_nasti_arready = 1'b0;
      s_nasti_wready  = 1'b0;
      s_nasti_bvalid  = 1'b0;
      s_nasti_rvalid  = 1'b0;
      s_nasti_rlast   = 1'b0;
      bram_en         = 1'b0;
      bram_we         = '0;
      case (state)
         IDLE: begin
            s_nasti_awready = grant_wr;
            s_nasti_arready = grant_rd;
         end
         WR_DATA: begin
            s_nasti_wready = 1'b1;
            bram_en        = s_nasti_wvalid;
            bram_we        = s_nasti_wvalid ? s_nasti_wstrb : '0;
         end
         WR_RESP:  s_nasti_bvalid = 1'b1;
         RD_ISSUE: bram_en = 1'b1;
         RD_DATA: begin
            s_nasti_rvalid = 1'b1;
            s_nasti_rlast  = last_beat;
         end
         default: ;
      endcase
   end

   // Burst context, beat counter, arbiter pointer and read holding register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_addr <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         id_q     <= '0;
         beat_q   <= '0;
         prio_wr  <= 1'b1;
         rd_fresh <= 1'b0;
         rd_hold  <= '0;
      end else begin
         if (state == IDLE && (grant_wr || grant_rd)) begin
            cur_addr <= grant_wr ? s_nasti_awaddr  : s_nasti_araddr;
            len_q    <= grant_wr ? s_nasti_awlen   : s_nasti_arlen;
            size_q   <= grant_wr ? s_nasti_awsize  : s_nasti_arsize;
            burst_q  <= grant_wr ? s_nasti_awburst : s_nasti_arburst;
            id_q     <= grant_wr ? s_nasti_awid    : s_nasti_arid;
            beat_q   <= '0;
            if (collide) prio_wr <= ~prio_wr;
         end
         if (w_hs || r_hs) begin
            beat_q   <= beat_q + 8'd1;
            cur_addr <= next_addr;
         end
         // BRAM output is only guaranteed on the first cycle after the read strobe
         rd_fresh <= (state == RD_ISSUE);
         if (rd_fresh) rd_hold <= bram_rddata;
      end
   end

   assign s_nasti_rdata = rd_fresh ? bram_rddata : rd_hold;
   assign s_nasti_rid   = id_q;
   assign s_nasti_bid   = id_q;
   assign s_nasti_rresp = 2'b00;
   assign s_nasti_bresp = 2'b00;

   // Out-of-range addresses simply lose their upper bits
   assign bram_addr   = BRAM_ADDR_WIDTH'(cur_addr) & ~BRAM_ADDR_WIDTH'(STRB - 1);
   assign bram_wrdata = s_nasti_wdata;
   assign bram_clk    = clk;
   assign bram_rst    = rst;

endmodule

// File: tb/tb_nasti_bram_bridge.sv
// tb/tb_nasti_bram_bridge.sv - randomized self-checking bench for nasti_bram_bridge
module tb_nasti_bram_bridge;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int BAW = 12;
   localparam int IW  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [IW-1:0]  awid = '0, arid = '0;
   logic [AW-1:0]  awaddr = '0, araddr = '0;
   logic [7:0]     awlen = '0, arlen = '0;
   logic [2:0]     awsize = '0, arsize = '0;
   logic [1:0]     awburst = '0, arburst = '0;
   logic           awvalid = 1'b0, arvalid = 1'b0;
   logic           awready, arready;
   logic [DW-1:0]  wdata = '0;
   logic [7:0]     wstrb = '0;
   logic           wlast = 1'b0, wvalid = 1'b0, wready;
   logic [IW-1:0]  bid, rid;
   logic [1:0]     bresp, rresp;
   logic           bvalid, bready = 1'b0;
   logic [DW-1:0]  rdata;
   logic           rlast, rvalid, rready = 1'b0;
   logic           bram_clk, bram_rst, bram_en;
   logic [7:0]     bram_we;
   logic [BAW-1:0] bram_addr;
   logic [DW-1:0]  bram_wrdata;
   logic [DW-1:0]  bram_rddata = '0;

   int checks = 0;
   int failures = 0;
   time aw_hs_t, ar_hs_t;
   bit exp_prio_wr = 1'b1;

   logic [63:0] mem     [0:511];
   logic [63:0] ref_mem [0:511];

   always #5 clk = ~clk;

   nasti_bram_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(BAW), .ID_WIDTH(IW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_nasti_awid(awid), .s_nasti_awaddr(awaddr), .s_nasti_awlen(awlen),
      .s_nasti_awsize(awsize), .s_nasti_awburst(awburst), .s_nasti_awvalid(awvalid),
      .s_nasti_awready(awready),
      .s_nasti_wdata(wdata), .s_nasti_wstrb(wstrb), .s_nasti_wlast(wlast),
      .s_nasti_wvalid(wvalid), .s_nasti_wready(wready),
      .s_nasti_bid(bid), .s_nasti_bresp(bresp), .s_nasti_bvalid(bvalid), .s_nasti_bready(bready),
      .s_nasti_arid(arid), .s_nasti_araddr(araddr), .s_nasti_arlen(arlen),
      .s_nasti_arsize(arsize), .s_nasti_arburst(arburst), .s_nasti_arvalid(arvalid),
      .s_nasti_arready(arready),
      .s_nasti_rid(rid), .s_nasti_rdata(rdata), .s_nasti_rresp(rresp), .s_nasti_rlast(rlast),
      .s_nasti_rvalid(rvalid), .s_nasti_rready(rready),
      .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en), .bram_we(bram_we),
      .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
   );

   // Synchronous BRAM: registered read, byte-enabled write
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we == 8'h00) bram_rddata <= mem[bram_addr[11:3]];
         else for (int b = 0; b < 8; b++)
            if (bram_we[b]) mem[bram_addr[11:3]][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Beat address sequence from the burst rules, in plain integer arithmetic
   function automatic logic [31:0] model_next(input logic [31:0] a, input int size, input int burst, input int len);
      longint unsigned nb, n, total, lo;
      nb = 64'd1 << size;
      n  = (longint'(a) / nb + 1) * nb;
      if (burst == 0) return a;
`ifdef NASTI_BRAM_WRAP_EN
      if (burst == 2) begin
         total = (len + 1) * nb;
         lo    = (longint'(a) / total) * total;
         if (n >= lo + total) n = lo;
      end
`else
      total = longint'(len);
      lo    = total;
`endif
      return n[31:0];
   endfunction

   function automatic logic [11:0] model_bram(input logic [31:0] a);
      return 12'((a % 4096) / 8 * 8);
   endfunction

   task automatic write_burst(input logic [31:0] addr, input int len, input int size, input int burst,
                              input logic [1:0] id, input logic [63:0] d0, input logic [7:0] s0, input bit gaps);
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      int n, idx;
      a = addr;
      awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awid = id; awvalid = 1'b1;
      #1; n = 0;
      while (!awready && n < 100) begin @(negedge clk); #1; n++; end
      check("aw_ready", awready, 1);
      aw_hs_t = $time;
      @(negedge clk); awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            wvalid = 1'b0; #1;
            check("w_gap_en", bram_en, 0);
            @(negedge clk);
         end
         d = (i == 0 && d0 != 0) ? d0 : {$urandom, $urandom};
         s = (s0 != 0) ? s0 : 8'($urandom_range(1, 255));
         wdata = d; wstrb = s; wlast = (i == len); wvalid = 1'b1; #1;
         check("w_ready", wready, 1);
         check("w_en", bram_en, 1);
         check("w_we", bram_we, s);
         check("w_addr", bram_addr, model_bram(a));
         check("w_data", bram_wrdata, d);
         idx = int'(model_bram(a)) / 8;
         for (int b = 0; b < 8; b++) if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
         a = model_next(a, size, burst, len);
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0; #1;
      check("b_valid", bvalid, 1);
      check("b_id", bid, id);
      check("b_resp", bresp, 0);
      check("b_en_idle", bram_en, 0);
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk); #1;
         check("b_hold", bvalid, 1);
      end
      bready = 1'b1;
      @(negedge clk); bready = 1'b0; #1;
      check("b_done", bvalid, 0);
   endtask

   task automatic read_burst(input logic [31:0] addr, input int len, input int size, input int burst,
                             input logic [1:0] id, input int stall_beat, input int stall_cyc);
      logic [31:0] a;
      logic [63:0] exp;
      int n;
      a = addr;
      araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arid = id; arvalid = 1'b1;
      #1; n = 0;
      while (!arready && n < 100) begin @(negedge clk); #1; n++; end
      check("ar_ready", arready, 1);
      ar_hs_t = $time;
      @(negedge clk); arvalid = 1'b0; #1;
      for (int i = 0; i <= len; i++) begin
         check("r_issue_en", bram_en, 1);
         check("r_issue_we", bram_we, 0);
         check("r_issue_addr", bram_addr, model_bram(a));
         check("r_issue_rvalid", rvalid, 0);
         exp = ref_mem[int'(model_bram(a)) / 8];
         @(negedge clk); #1;
         check("r_valid", rvalid, 1);
         check("r_data", rdata, exp);
         check("r_last", rlast, (i == len));
         check("r_id", rid, id);
         check("r_resp", rresp, 0);
         check("r_data_en", bram_en, 0);
         if (i == stall_beat) begin
            repeat (stall_cyc) begin
               @(negedge clk); #1;
               check("r_hold_valid", rvalid, 1);
               check("r_hold_data", rdata, exp);
               check("r_hold_en", bram_en, 0);
            end
         end
         rready = 1'b1;
         @(negedge clk); rready = 1'b0; #1;
         a = model_next(a, size, burst, len);
      end
      check("r_done", rvalid, 0);
   endtask

   task automatic collide(input logic [31:0] wa, input logic [31:0] ra);
      fork
         write_burst(wa, 1, 3, 1, 2'd2, 64'd0, 8'hFF, 1'b0);
         read_burst(ra, 2, 3, 1, 2'd3, -1, 0);
      join
      check("col_order_write_first", (aw_hs_t < ar_hs_t), exp_prio_wr);
      exp_prio_wr = !exp_prio_wr;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int len, size, burst;
      logic [31:0] addr;
      for (int i = 0; i < 512; i++) begin
         mem[i]     = (i < 8) ? 64'(i + 1) : {$urandom, $urandom};
         ref_mem[i] = mem[i];
      end

      repeat (2) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_en", bram_en, 0);
      check("rst_we", bram_we, 0);
      check("rst_addr", bram_addr, 0);
      check("rst_bram_rst", bram_rst, 1);
      check("bram_clk", bram_clk, clk);
      rst = 1'b0;
      @(negedge clk);

      // 8-beat INCR read of 1..8
      read_burst(32'h0, 7, 3, 1, 2'd1, -1, 0);
      // single-beat write
      write_burst(32'h10, 0, 3, 1, 2'd1, 64'h1122334455667788, 8'hFF, 1'b0);
      check("mem_after_write", mem[2], 64'h1122334455667788);
      // partial strobe
      write_burst(32'h8, 0, 3, 1, 2'd0, 64'd0, 8'h0F, 1'b0);
      read_burst(32'h8, 1, 3, 1, 2'd0, -1, 0);
      // backpressure mid-burst
      read_burst(32'h40, 5, 3, 1, 2'd2, 3, 5);
      // out-of-range address wraps into the BRAM
      write_burst(32'h0000_1018, 0, 3, 1, 2'd3, 64'hCAFEF00D_DEADBEEF, 8'hFF, 1'b0);
      read_burst(32'h18, 0, 3, 1, 2'd3, -1, 0);
      // two collisions: write first, then read first
      collide(32'h100, 32'h200);
      collide(32'h300, 32'h400);

      // reset in the middle of a 4-beat read
      araddr = 32'h80; arlen = 8'd3; arsize = 3'd3; arburst = 2'd1; arid = 2'd1; arvalid = 1'b1;
      #1;
      check("rr_arready", arready, 1);
      @(negedge clk); arvalid = 1'b0;
      @(negedge clk); #1;
      check("rr_rvalid_b0", rvalid, 1);
      rready = 1'b1;
      @(negedge clk); rready = 1'b0;
      @(negedge clk); #1;
      check("rr_rvalid_b1", rvalid, 1);
      rst = 1'b1; #1;
      check("rr_rst_rvalid", rvalid, 0);
      check("rr_rst_en", bram_en, 0);
      @(negedge clk); rst = 1'b0;
      exp_prio_wr = 1'b1;
      @(negedge clk); #1;
      check("rr_after_rvalid", rvalid, 0);
      check("rr_after_en", bram_en, 0);
      write_burst(32'h88, 0, 3, 1, 2'd2, 64'd0, 8'hFF, 1'b0);
      read_burst(32'h88, 0, 3, 1, 2'd2, -1, 0);

      // randomized traffic
      for (int t = 0; t < 30; t++) begin
         size  = $urandom_range(0, 3);
         burst = $urandom_range(0, 2);
         len   = $urandom_range(0, 7);
         addr  = 32'($urandom_range(0, 16'h3FFF));
`ifdef NASTI_BRAM_WRAP_EN
         if (burst == 2) begin
            len  = (1 << $urandom_range(1, 3)) - 1;
            addr = addr & ~((32'd1 << size) - 1);
         end
`endif
         if ($urandom_range(0, 1) == 0)
            write_burst(addr, len, size, burst, 2'($urandom), 64'd0, 8'd0, 1'b1);
         else
            read_burst(addr, len, size, burst, 2'($urandom), $urandom_range(0, len), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
